// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: WIDTH-bit pipelined adder with carry-in and carry-out.
// The carry chain is cut into SEGS equal segments of SW = WIDTH/SEGS bits.
// Pipeline stage k resolves segment k-1. It carries forward the finished
// lower sum bits and only the operand slices that are still unconsumed.
// Valid/ready handshake on both sides, with a global stall:
// when the output is held, every stage freezes.
// Optional macro SEG_PIPE_ADDER_SUB_EN adds the 'sub' input
// (a - b, cin ignored) and the 'ovf' output (signed overflow).
module seg_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEGS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEG_PIPE_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int SW = WIDTH / SEGS;

  // Stop elaboration on a segment count that cannot split WIDTH evenly.
  if (SEGS < 1 || SEGS > WIDTH || (WIDTH % SEGS) != 0) begin : g_bad_cfg
    $error("seg_pipe_adder: WIDTH (%0d) must be a multiple of SEGS (%0d), 1 <= SEGS <= WIDTH",
           WIDTH, SEGS);
  end

  logic             stall;
  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // A result sitting at the output that nobody takes freezes the whole pipe.
  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = !stall;

`ifdef SEG_PIPE_ADDER_SUB_EN
  // Subtraction is a + ~b + 1. The +1 rides in on the stage-1 carry.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  for (genvar gi = 0; gi < SEGS; gi++) begin : g_stage
    // IW: operand bits still to be added when entering this stage.
    // LW: sum bits resolved once this stage has registered.
    localparam int IW      = WIDTH - gi * SW;
    localparam int LW      = (gi + 1) * SW;
    localparam bit IS_LAST = (gi == SEGS - 1);

    logic          v_in;
    logic          c_in;
    logic [IW-1:0] a_up;
    logic [IW-1:0] b_up;
    logic [SW:0]   seg;
    logic [LW-1:0] sum_new;
    logic          load;

    logic          valid_reg;
    logic          carry_reg;
    logic [LW-1:0] sum_reg;

    if (gi == 0) begin : g_src
      assign v_in    = in_valid;
      assign c_in    = cin_eff;
      assign a_up    = a;
      assign b_up    = b_eff;
      assign sum_new = seg[SW-1:0];
    end else begin : g_src
      assign v_in    = g_stage[gi-1].valid_reg;
      assign c_in    = g_stage[gi-1].carry_reg;
      assign a_up    = g_stage[gi-1].g_rem.a_rem_reg;
      assign b_up    = g_stage[gi-1].g_rem.b_rem_reg;
      assign sum_new = {seg[SW-1:0], g_stage[gi-1].sum_reg};
    end

    // The lowest unconsumed slice is always at the bottom of a_up/b_up.
    assign seg = {1'b0, a_up[SW-1:0]} + {1'b0, b_up[SW-1:0]} + {{SW{1'b0}}, c_in};

    // The output stage skips bubbles so that sum/cout keep the last result.
    assign load = advance && (!IS_LAST || v_in);

    // Stage occupancy moves with the pipe whenever it is not stalled.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
      end else if (advance) begin
        valid_reg <= v_in;
      end
    end

    // Partial sum and segment carry for this stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_reg   <= '0;
        carry_reg <= 1'b0;
      end else if (load) begin
        sum_reg   <= sum_new;
        carry_reg <= seg[SW];
      end
    end

    if (!IS_LAST) begin : g_rem
      logic [IW-SW-1:0] a_rem_reg;
      logic [IW-SW-1:0] b_rem_reg;

      // Forward only the operand slices that later stages still need.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_rem_reg <= '0;
          b_rem_reg <= '0;
        end else if (load) begin
          a_rem_reg <= a_up[IW-1:SW];
          b_rem_reg <= b_up[IW-1:SW];
        end
      end
    end

`ifdef SEG_PIPE_ADDER_SUB_EN
    if (IS_LAST) begin : g_ovf
      logic ovf_reg;

      // Signed overflow: carry into the MSB xor carry out of the MSB.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (load) begin
          ovf_reg <= a_up[IW-1] ^ b_up[IW-1] ^ seg[SW-1] ^ seg[SW];
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[SEGS-1].valid_reg;
  assign sum       = g_stage[SEGS-1].sum_reg;
  assign cout      = g_stage[SEGS-1].carry_reg;
`ifdef SEG_PIPE_ADDER_SUB_EN
  assign ovf       = g_stage[SEGS-1].g_ovf.ovf_reg;
`endif

endmodule
